// File: rtl/spi_master_pkg.sv
// ---------------------------------------------------------------
// spi_master_pkg: frame constants, state encoding, frame builder. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

package spi_master_pkg;

  localparam int SPI_FRAME_BITS = 16;
  localparam int SPI_RW_BIT     = 15;
  localparam int SPI_ADDR_MSB   = 14;
  localparam int SPI_ADDR_LSB   = 8;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_SETUP    = 3'd1,
    ST_SHIFT_HI = 3'd2,
    ST_SHIFT_LO = 3'd3,
    ST_GAP      = 3'd4
  } state_t;

  // Read frames carry a zero data byte; the slave drives the read byte back on MISO.
  function automatic logic [SPI_FRAME_BITS-1:0] build_frame(input logic       rw,
                                                            input logic [6:0] addr,
                                                            input logic [7:0] wdata);
    return {rw, addr, (rw ? wdata : 8'h00)};
  endfunction

endpackage

`default_nettype wire

// File: rtl/spi_clk_div.sv
// ---------------------------------------------------------------
// spi_clk_div: phase timer, one-cycle tick after DIV enabled cycles. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module spi_clk_div #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic enable,
  output logic tick
);

  localparam int CW = (DIV < 1) ? 1 : $clog2(DIV + 1);

  logic [CW-1:0] cnt;

  assign tick = enable && (cnt == CW'(DIV - 1));

  // Reloads on every tick so each phase restarts from zero; never wraps.
  always_ff @(posedge clk) begin
    if (rst || restart) begin
      cnt <= '0;
    end else if (enable) begin
      cnt <= tick ? '0 : cnt + CW'(1);
    end
  end

endmodule

`default_nettype wire

// File: rtl/spi_master.sv
// ---------------------------------------------------------------
// spi_master: 16-bit register-access SPI master, mode 0, MSB first. Rev 1.0
// ---------------------------------------------------------------
`default_nettype none

module spi_master
  import spi_master_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int CS_GAP  = 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       START,
  input  logic       RW,
  input  logic [6:0] ADDR,
  input  logic [7:0] WDATA,
  output logic       BUSY,
  output logic       DONE,
  output logic [7:0] RDATA,
  output logic       CSN,
  output logic       SCLK,
  output logic       MOSI,
  input  logic       MISO
);

  // GAP plus the following IDLE cycle together give CS_GAP cycles of CSN high.
  localparam int GAP_LEN = (CS_GAP > 1) ? CS_GAP - 1 : 1;
  localparam int GW      = $clog2(GAP_LEN + 1);

  state_t                    state;
  state_t                    state_n;
  logic [SPI_FRAME_BITS-1:0] tx;
  logic [SPI_FRAME_BITS-1:0] rx;
  logic [SPI_FRAME_BITS-1:0] frame;
  logic [3:0]                bit_cnt;
  logic [GW-1:0]             gap_cnt;
  logic                      rw_q;
  logic                      mosi_q;
  logic                      done_q;
  logic [7:0]                rdata_q;
  logic                      div_restart;
  logic                      div_en;
  logic                      tick;

  assign frame = build_frame(RW, ADDR, WDATA);

  spi_clk_div #(
    .DIV(CLK_DIV)
  ) u_clk_div (
    .clk    (CLK),
    .rst    (RST),
    .restart(div_restart),
    .enable (div_en),
    .tick   (tick)
  );

  always_comb begin
    state_n     = state;
    div_restart = 1'b0;
    div_en      = 1'b0;
    case (state)
      ST_IDLE: begin
        div_restart = 1'b1;
        if (START) state_n = ST_SETUP;
      end
      ST_SETUP: begin
        div_en = 1'b1;
        if (tick) state_n = ST_SHIFT_HI;
      end
      ST_SHIFT_HI: begin
        div_en = 1'b1;
        if (tick) state_n = ST_SHIFT_LO;
      end
      ST_SHIFT_LO: begin
        div_en = 1'b1;
        if (tick) state_n = (bit_cnt == 4'd15) ? ST_GAP : ST_SHIFT_HI;
      end
      ST_GAP: begin
        if (gap_cnt == GW'(GAP_LEN - 1)) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= ST_IDLE;
      tx      <= '0;
      rx      <= '0;
      bit_cnt <= '0;
      gap_cnt <= '0;
      rw_q    <= 1'b0;
      mosi_q  <= 1'b0;
      done_q  <= 1'b0;
      rdata_q <= 8'h00;
    end else begin
      state  <= state_n;
      done_q <= (state == ST_SHIFT_LO) && (state_n == ST_GAP);

      if ((state == ST_IDLE) && START) begin
        tx      <= {frame[SPI_FRAME_BITS-2:0], 1'b0};
        mosi_q  <= frame[SPI_RW_BIT];
        rw_q    <= RW;
        rx      <= '0;
        bit_cnt <= '0;
      end

      // MISO is sampled on the CLK edge that raises SCLK.
      if ((state_n == ST_SHIFT_HI) && (state != ST_SHIFT_HI)) begin
        rx <= {rx[SPI_FRAME_BITS-2:0], MISO};
      end

      // Falling SCLK presents the next bit; the last bit is held through the final low phase.
      if ((state == ST_SHIFT_HI) && (state_n == ST_SHIFT_LO) && (bit_cnt != 4'd15)) begin
        mosi_q <= tx[SPI_FRAME_BITS-1];
        tx     <= {tx[SPI_FRAME_BITS-2:0], 1'b0};
      end

      if ((state == ST_SHIFT_LO) && (state_n == ST_SHIFT_HI)) begin
        bit_cnt <= bit_cnt + 4'd1;
      end

      if ((state == ST_SHIFT_LO) && (state_n == ST_GAP)) begin
        mosi_q  <= 1'b0;
        gap_cnt <= '0;
        if (!rw_q) rdata_q <= rx[7:0];
      end else if (state == ST_GAP) begin
        gap_cnt <= gap_cnt + GW'(1);
      end
    end
  end

  assign CSN   = !((state == ST_SETUP) || (state == ST_SHIFT_HI) || (state == ST_SHIFT_LO));
  assign SCLK  = (state == ST_SHIFT_HI);
  assign MOSI  = mosi_q;
  assign BUSY  = (state != ST_IDLE);
  assign DONE  = done_q;
  assign RDATA = rdata_q;

endmodule

`default_nettype wire
